exu_seq_ctrl: RTL

Multi-cycle sequencer for the single-issue RV64 core. It owns the PC and the instruction register, and steps each instruction through fetch, execute, memory and writeback around the combinational execute unit and register file. It issues valid/ready requests to the instruction and data memory ports, commits writeback and next-PC, and stops the core on ebreak, on an invalid opcode, or on a memory-response timeout. It also keeps cycle and retired-instruction counters.

---
 rtl/exu_seq_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/exu_seq_ctrl.sv
// Multi-cycle instruction sequencer for the single-issue RV64 core: owns PC and IR,
// drives the fetch/data memory handshakes, commits writeback and keeps perf counters.
module exu_seq_ctrl #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned     TMO_W    = 8
) (
  input  logic            clk,
  input  logic            rst,

  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,

  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,

  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_is_jump,
  input  logic            dec_rf_wen,
  input  logic            dec_ebreak,
  input  logic            dec_invalid,
  input  logic [XLEN-1:0] exu_result,
  input  logic [XLEN-1:0] exu_dnpc,

  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_data,

  output logic            rf_wen,
  output logic [XLEN-1:0] rf_wdata,

  output logic            halted,
  output logic            trapped,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);

  typedef enum logic [2:0] {
    F_REQ, F_WAIT, EXEC, M_REQ, M_WAIT, WB, HALT, TRAP
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // A wait cycle that still sees no response while the counter sits one below
  // all-ones is the last one; a response in that same cycle still wins.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   daddr_q, daddr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              halted_q, halted_d;
  logic              trapped_q, trapped_d;
  logic [63:0]       cycle_q;
  logic [63:0]       instret_q, instret_d;
  logic              tmo_expired;

  assign tmo_expired = (tmo_q == TMO_LAST);

  // NOTE: every variable assigned here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    wdata_d        = wdata_q;
    daddr_d        = daddr_q;
    instret_d      = instret_q;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_we        = 1'b0;
    rf_wen         = 1'b0;

    unique case (state_q)
      F_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = F_WAIT;
      end
      F_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = EXEC;
        end else if (tmo_expired) begin
          state_d = TRAP;
        end
      end
      EXEC: begin
        if (dec_invalid) begin
          state_d = TRAP;
        end else if (dec_ebreak) begin
          instret_d = instret_q + 64'd1;
          state_d   = HALT;
        end else if (dec_is_load || dec_is_store) begin
          daddr_d = exu_result;
          state_d = M_REQ;
        end else begin
          wdata_d = exu_result;
          state_d = WB;
        end
      end
      M_REQ: begin
        dmem_req_valid = 1'b1;
        dmem_we        = dec_is_store;
        if (dmem_req_ready) state_d = M_WAIT;
      end
      M_WAIT: begin
        if (dmem_rsp_valid) begin
          if (dec_is_load) wdata_d = dmem_rsp_data;
          state_d = WB;
        end else if (tmo_expired) begin
          state_d = TRAP;
        end
      end
      WB: begin
        rf_wen    = dec_rf_wen && !dec_is_store;
        pc_d      = dec_is_jump ? exu_dnpc : pc_q + XLEN'(4);
        instret_d = instret_q + 64'd1;
        state_d   = F_REQ;
      end
      HALT, TRAP: begin
      end
    endcase

    // Wait counter restarts on every state change and only runs while waiting.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q == F_WAIT || state_q == M_WAIT) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = tmo_q;
    end

    halted_d  = halted_q  || (state_d == HALT);
    trapped_d = trapped_q || (state_d == TRAP);

    // While reset is held the state already reads F_REQ; keep the handshakes quiet.
    if (!rst) begin
      imem_req_valid = 1'b0;
      dmem_req_valid = 1'b0;
      dmem_we        = 1'b0;
      rf_wen         = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= F_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      wdata_q   <= '0;
      daddr_q   <= '0;
      tmo_q     <= '0;
      halted_q  <= 1'b0;
      trapped_q <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      wdata_q   <= wdata_d;
      daddr_q   <= daddr_d;
      tmo_q     <= tmo_d;
      halted_q  <= halted_d;
      trapped_q <= trapped_d;
      cycle_q   <= cycle_q + 64'd1;
      instret_q <= instret_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign dmem_addr   = daddr_q;
  assign rf_wdata    = wdata_q;
  assign halted      = halted_q;
  assign trapped     = trapped_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
